dcache: RTL

DCACHE -- requirements
Module: dcache

---
 rtl/dcache_pkg.sv | 13 +
 rtl/dcache_array.sv | 51 +++++
 rtl/dcache.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped write-back data cache.
package dcache_pkg;
  localparam int REQ_AW = 12;
  localparam int MEM_AW = 11;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WBACK,
    S_REFILL,
    S_RESP
  } state_e;
endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty flags, tags and doubleword data.
// One asynchronous read port and one whole-entry write port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int TAG_W = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(LINES)-1:0] i_rd_idx,
  output logic                     o_rd_valid,
  output logic                     o_rd_dirty,
  output logic [TAG_W-1:0]         o_rd_tag,
  output logic [DATA_W-1:0]        o_rd_data,
  input  logic                     i_wr_en,
  input  logic [$clog2(LINES)-1:0] i_wr_idx,
  input  logic                     i_wr_valid,
  input  logic                     i_wr_dirty,
  input  logic [TAG_W-1:0]         i_wr_tag,
  input  logic [DATA_W-1:0]        i_wr_data
);
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_dirty = r_dirty[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= i_wr_valid;
      r_dirty[i_wr_idx] <= i_wr_dirty;
    end
  end

  // NOTE: tag/data arrays stay unreset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end
endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with one doubleword per line.
// A single FSM sequences hit response, dirty-victim writeback and refill.
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int TAG_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REQ_AW-1:0] dcache_req_addr,
  input  logic              dcache_req_valid,
  input  logic              dcache_req_rw,
  input  logic [DATA_W-1:0] dcache_data_write,
  output logic [DATA_W-1:0] dcache_data_read,
  output logic              dcache_ready,
  output logic              dcache_hit,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [MEM_AW-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  localparam int IDX_W = $clog2(LINES);

  state_e            r_state;
  state_e            w_next;
  logic [DATA_W-1:0] r_data_read;
  logic [DATA_W-1:0] w_rd_next;
  logic              w_rd_load;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_unused;

  logic              w_line_valid;
  logic              w_line_dirty;
  logic [TAG_W-1:0]  w_line_tag;
  logic [DATA_W-1:0] w_line_data;

  logic              w_we;
  logic              w_wr_dirty;
  logic [TAG_W-1:0]  w_wr_tag;
  logic [DATA_W-1:0] w_wr_data;

  assign w_idx    = dcache_req_addr[IDX_W:1];
  assign w_tag    = dcache_req_addr[REQ_AW-1:IDX_W+1];
  assign w_unused = dcache_req_addr[0];

  dcache_array #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_line_valid),
    .o_rd_dirty (w_line_dirty),
    .o_rd_tag   (w_line_tag),
    .o_rd_data  (w_line_data),
    .i_wr_en    (w_we),
    .i_wr_idx   (w_idx),
    .i_wr_valid (1'b1),
    .i_wr_dirty (w_wr_dirty),
    .i_wr_tag   (w_wr_tag),
    .i_wr_data  (w_wr_data)
  );

  assign dcache_hit       = dcache_req_valid & w_line_valid & (w_line_tag == w_tag);
  assign dcache_data_read = r_data_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_data_read <= '0;
    end else begin
      r_state <= w_next;
      if (w_rd_load) r_data_read <= w_rd_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_next        = r_state;
    w_rd_load     = 1'b0;
    w_rd_next     = r_data_read;
    w_we          = 1'b0;
    w_wr_dirty    = 1'b0;
    w_wr_tag      = w_tag;
    w_wr_data     = dcache_data_write;
    dcache_ready  = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_wdata     = '0;
    unique case (r_state)
      S_IDLE: begin
        if (dcache_req_valid) begin
          if (dcache_hit) begin
            w_next    = S_RESP;
            w_rd_load = 1'b1;
            if (dcache_req_rw) begin
              w_we       = 1'b1;
              w_wr_dirty = 1'b1;
              w_rd_next  = dcache_data_write;
            end else begin
              w_rd_next  = w_line_data;
            end
          end else if (w_line_valid && w_line_dirty) begin
            w_next = S_WBACK;
          end else begin
            w_next = S_REFILL;
          end
        end
      end
      S_WBACK: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {w_line_tag, w_idx};
        mem_wdata     = w_line_data;
        if (mem_ready) begin
          // Rewrite the victim unchanged except for the dirty flag.
          w_we      = 1'b1;
          w_wr_tag  = w_line_tag;
          w_wr_data = w_line_data;
          w_next    = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = dcache_req_addr[REQ_AW-1:1];
        if (mem_ready) begin
          w_we       = 1'b1;
          w_wr_dirty = dcache_req_rw;
          w_wr_data  = dcache_req_rw ? dcache_data_write : mem_rdata;
          w_rd_load  = 1'b1;
          w_rd_next  = w_wr_data;
          w_next     = S_RESP;
        end
      end
      S_RESP: begin
        dcache_ready = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule
